// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if -- bus bundle for the scoreboarded register file.
//
// Groups every port of regfile_sb except clk/reset:
//   read ports   : rd_addr_1/2 (in), rd_data_1/2, rd_busy_1/2 (out)
//   writeback    : wr_en, wr_addr, wr_data (in)
//   HI/LO        : hi_wr_en, lo_wr_en, hi_wr_data, lo_wr_data (in),
//                  hi_data, lo_data (out)
//   issue        : issue_en, issue_addr, issue_hilo (in)
//   status       : issue_ready, hilo_busy, busy_count, err (out)
// The slave modport is the register file; the master modport is the
// pipeline (or bench) driving it.
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              rd_busy_1;
    logic              rd_busy_2;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              hi_wr_en;
    logic              lo_wr_en;
    logic [DATA_W-1:0] hi_wr_data;
    logic [DATA_W-1:0] lo_wr_data;
    logic [DATA_W-1:0] hi_data;
    logic [DATA_W-1:0] lo_data;

    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_hilo;

    logic              issue_ready;
    logic              hilo_busy;
    logic [ADDR_W:0]   busy_count;
    logic              err;

    modport slave (
        input  rd_addr_1, rd_addr_2,
        output rd_data_1, rd_data_2, rd_busy_1, rd_busy_2,
        input  wr_en, wr_addr, wr_data,
        input  hi_wr_en, lo_wr_en, hi_wr_data, lo_wr_data,
        output hi_data, lo_data,
        input  issue_en, issue_addr, issue_hilo,
        output issue_ready, hilo_busy, busy_count, err
    );

    modport master (
        output rd_addr_1, rd_addr_2,
        input  rd_data_1, rd_data_2, rd_busy_1, rd_busy_2,
        output wr_en, wr_addr, wr_data,
        output hi_wr_en, lo_wr_en, hi_wr_data, lo_wr_data,
        input  hi_data, lo_data,
        output issue_en, issue_addr, issue_hilo,
        input  issue_ready, hilo_busy, busy_count, err
    );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- register file with write-back scoreboard and HI/LO pair.
//
// Ports:
//   clk    : single clock, all state changes on its rising edge
//   reset  : asynchronous active-low reset (0 = in reset)
//   bus    : regfile_sb_if.slave, carrying two combinational read ports with
//            per-register busy flags, one writeback port, HI/LO writeback
//            and read, the issue port (register and HI/LO) and status
//            outputs (issue_ready, hilo_busy, busy_count, sticky err).
//
// Register 0 is hard-wired to zero and never tracked by the scoreboard.
// With BYPASS=1 a writeback is visible on the read ports (data and busy)
// and on hi_data/lo_data in the same cycle it is presented.
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_sb_if.slave    bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam bit BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              hilo_busy_q, hilo_busy_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;

    logic wr_live;
    logic issue_live;
    logic issue_ok;
    logic waw;
    logic hilo_wr;
    logic hilo_issue_ok;
    logic hilo_waw;
    logic byp_1, byp_2;

    // Writes and issues aimed at register 0 are no-ops for state.
    assign wr_live    = bus.wr_en    && (bus.wr_addr    != '0);
    assign issue_live = bus.issue_en && (bus.issue_addr != '0);

    // A writeback in this cycle frees its target in time for a new issue.
    assign bus.issue_ready = (bus.issue_addr == '0)
                           || !busy_q[bus.issue_addr]
                           || (bus.wr_en && (bus.wr_addr == bus.issue_addr));

    assign issue_ok = issue_live && bus.issue_ready;
    assign waw      = bus.issue_en && !bus.issue_ready;

    assign hilo_wr       = bus.hi_wr_en || bus.lo_wr_en;
    assign hilo_issue_ok = bus.issue_hilo && (!hilo_busy_q || hilo_wr);
    assign hilo_waw      = bus.issue_hilo && hilo_busy_q && !hilo_wr;

    // Forwarding hit per read port; never for register 0.
    assign byp_1 = BYP && wr_live && (bus.wr_addr == bus.rd_addr_1);
    assign byp_2 = BYP && wr_live && (bus.wr_addr == bus.rd_addr_2);

    assign bus.rd_data_1 = (bus.rd_addr_1 == '0) ? '0 :
                           byp_1 ? bus.wr_data : regs_q[bus.rd_addr_1];
    assign bus.rd_data_2 = (bus.rd_addr_2 == '0) ? '0 :
                           byp_2 ? bus.wr_data : regs_q[bus.rd_addr_2];

    assign bus.rd_busy_1 = (bus.rd_addr_1 != '0) && busy_q[bus.rd_addr_1] && !byp_1;
    assign bus.rd_busy_2 = (bus.rd_addr_2 != '0) && busy_q[bus.rd_addr_2] && !byp_2;

    assign bus.hi_data = (BYP && bus.hi_wr_en) ? bus.hi_wr_data : hi_q;
    assign bus.lo_data = (BYP && bus.lo_wr_en) ? bus.lo_wr_data : lo_q;

    assign bus.hilo_busy  = hilo_busy_q;
    assign bus.busy_count = busy_count_q;
    assign bus.err        = err_q;

    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        hilo_busy_d  = hilo_busy_q;
        err_d        = err_q;
        busy_count_d = '0;

        if (wr_live) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            busy_d[bus.wr_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue leaves the entry busy.
        if (issue_ok) begin
            busy_d[bus.issue_addr] = 1'b1;
        end

        if (bus.hi_wr_en) hi_d = bus.hi_wr_data;
        if (bus.lo_wr_en) lo_d = bus.lo_wr_data;
        if (hilo_wr)       hilo_busy_d = 1'b0;
        if (hilo_issue_ok) hilo_busy_d = 1'b1;

        if (waw || hilo_waw) err_d = 1'b1;

        // Count is taken from next-state bits so it tracks busy exactly.
        for (int i = 1; i < NREG; i++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            hilo_busy_q  <= 1'b0;
            err_q        <= 1'b0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q       <= busy_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            hilo_busy_q  <= hilo_busy_d;
            err_q        <= err_d;
            busy_count_q <= busy_count_d;
        end
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001: Parameter DATA_W, default 32, register and HI/LO data width in bits.
REQ-002: Parameter ADDR_W, default 5, register address width; register count NREG = 2**ADDR_W.
REQ-003: Parameter BYPASS, default 1, 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-004: clk  in  1  single clock; all state updates on posedge clk.
REQ-005: reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006: rd_addr_1, rd_addr_2  in  ADDR_W  read port addresses.
REQ-007: rd_data_1, rd_data_2  out  DATA_W  combinational read data.
REQ-008: rd_busy_1, rd_busy_2  out  1  scoreboard busy flag of the addressed register.
REQ-009: wr_en  in  1, wr_addr  in  ADDR_W, wr_data  in  DATA_W  writeback port.
REQ-010: hi_wr_en, lo_wr_en  in  1, hi_wr_data, lo_wr_data  in  DATA_W  HI/LO writeback.
REQ-011: hi_data, lo_data  out  DATA_W  current HI/LO values, with bypass per REQ-018.
REQ-012: issue_en  in  1, issue_addr  in  ADDR_W  mark destination register pending.
REQ-013: issue_hilo  in  1  mark HI/LO pending.
REQ-014: issue_ready  out  1, hilo_busy  out  1, busy_count  out  ADDR_W+1, err  out  1.

Function
REQ-015: Register writes on posedge clk when wr_en=1; HI/LO written independently by hi_wr_en/lo_wr_en.
REQ-016: Register 0 reads 0, ignores writes, never becomes busy, and issue_en to address 0 has no effect.
REQ-017: BYPASS=1: if wr_en=1, wr_addr=rd_addr_n and rd_addr_n!=0, rd_data_n = wr_data in the same cycle; BYPASS=0: rd_data_n = stored value.
REQ-018: BYPASS=1: hi_data = hi_wr_data while hi_wr_en=1, lo_data = lo_wr_data while lo_wr_en=1.
REQ-019: Scoreboard: one busy bit per register; issue_en sets busy[issue_addr] at the clock edge; wr_en clears busy[wr_addr].
REQ-020: Set and clear of the same address in one cycle: set wins (busy=1 after edge, data written).
REQ-021: Writeback to a non-busy register is legal: data written, busy stays 0.
REQ-022: rd_busy_n = busy[rd_addr_n] AND NOT (BYPASS=1, wr_en=1, wr_addr=rd_addr_n); forced 0 for address 0.
REQ-023: issue_ready = NOT busy[issue_addr] OR (wr_en=1 AND wr_addr=issue_addr); forced 1 for address 0.
REQ-024: issue_en while issue_ready=0 (WAW) is ignored, leaves state unchanged, and sets sticky err.
REQ-025: hilo_busy set by issue_hilo, cleared by hi_wr_en OR lo_wr_en; set wins on simultaneous events.
REQ-026: issue_hilo while hilo_busy=1 and no HI/LO write in that cycle is ignored and sets err.
REQ-027: busy_count = number of set busy bits in registers 1..NREG-1, registered, updated at the same edge as busy bits; range 0..NREG-1, no wrap.
REQ-028: err clears only on reset.

Reset
REQ-029: reset=0 asynchronously clears all registers, HI, LO, busy bits, hilo_busy and err to 0; busy_count=0, issue_ready=1.
REQ-030: Writes and issues presented while reset=0 are discarded; first update occurs on the first posedge clk after reset deasserts.
REQ-031: Reset asserted mid-operation aborts all pending scoreboard entries without a writeback.

Verification
REQ-032: Reset, then read every address -> all rd_data=0, rd_busy=0, busy_count=0, err=0.
REQ-033: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr_1=5 same cycle -> rd_data_1=0xDEADBEEF (BYPASS=1) or 0 (BYPASS=0); next cycle 0xDEADBEEF in both builds.
REQ-034: issue_en addr 7 -> rd_busy=1 for addr 7, busy_count=1; second issue addr 7 -> ignored, err=1; wr_en addr 7 data 0x12 -> busy=0, busy_count=0, reads 0x12.
REQ-035: Same cycle issue_en addr 3 and wr_en addr 3 (busy) -> data written, busy[3]=1, issue_ready=1 during that cycle, err=0.
REQ-036: wr_en addr 0 data 0xFFFFFFFF and issue_en addr 0 -> rd_data=0, busy_count unchanged; issue_hilo then hi_wr_en 0xA -> hilo_busy 1 then 0, hi_data=0xA.
REQ-037: Issue addrs 1..4, assert reset mid-sequence -> all busy=0, busy_count=0, err=0 immediately, without a clock edge.
